// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared core constants and fetch queue entry type
package instruction_fetch_pkg;

    localparam int XLEN      = 32;
    localparam int IFQ_DEPTH = 2;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    localparam fetch_entry_t RESET_ENTRY = '{pc: '0, inst: NOP_INST};

endpackage

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - shift-register {pc, inst} queue with flush and occupancy
module fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter  int DEPTH = IFQ_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_valid,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output logic          head_valid,
    output fetch_entry_t  head_data,
    output logic [CW-1:0] occupancy
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] wr_idx;
    logic          pop_en;
    logic          push_en;

    // Slot 0 is always the head, so a waiting head never moves until popped.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        pop_en  = pop && (count_q != '0);
        wr_idx  = count_q - CW'(pop_en);
        push_en = push_valid && (wr_idx < CW'(DEPTH));
        if (flush) begin
            count_d = '0;
        end else begin
            if (pop_en) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
            end
            if (push_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == wr_idx) begin
                        mem_d[i] = push_data;
                    end
                end
            end
            count_d = count_q - CW'(pop_en) + CW'(push_en);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_ENTRY;
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[0];
    assign occupancy  = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - credit-limited instruction fetch with redirect and stale-response drop
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    input  logic            out_ready
);

    localparam int CW = $clog2(IFQ_DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] infl_q [IFQ_DEPTH];
    logic [XLEN-1:0] infl_d [IFQ_DEPTH];
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   infl_wr_idx;
    logic [CW-1:0]   q_occ;
    logic [CW:0]     credit_used;
    logic            rsp;
    logic            accept;
    logic            q_push, q_pop, q_flush;
    fetch_entry_t    q_push_data;
    fetch_entry_t    q_head;

    // Queued plus in-flight words never exceed the queue depth, so every response has a slot.
    assign credit_used = {1'b0, q_occ} + {1'b0, outstanding_q};
    assign imem_req    = !rst && !redirect && (credit_used < (CW+1)'(IFQ_DEPTH));
    assign imem_addr   = fetch_pc_q;
    assign accept      = imem_req && imem_ready;
    assign rsp         = imem_rvalid && (outstanding_q != '0);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        infl_d        = infl_q;
        outstanding_d = outstanding_q - CW'(rsp) + CW'(accept);
        drop_d        = drop_q;
        infl_wr_idx   = outstanding_q - CW'(rsp);
        q_push        = 1'b0;
        q_pop         = 1'b0;
        q_flush       = 1'b0;
        q_push_data   = '{pc: infl_q[0], inst: imem_rdata};

        if (rsp) begin
            for (int i = 0; i < IFQ_DEPTH - 1; i++) begin
                infl_d[i] = infl_q[i+1];
            end
        end
        if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            for (int i = 0; i < IFQ_DEPTH; i++) begin
                if (CW'(i) == infl_wr_idx) begin
                    infl_d[i] = fetch_pc_q;
                end
            end
        end

        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            q_flush    = 1'b1;
            drop_d     = outstanding_q - CW'(rsp);
        end else begin
            if (rsp) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    q_push = 1'b1;
                end
            end
            q_pop = out_valid && out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC & ~XLEN'(3);
            outstanding_q <= '0;
            drop_q        <= '0;
            for (int i = 0; i < IFQ_DEPTH; i++) begin
                infl_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            infl_q        <= infl_d;
        end
    end

    fetch_queue #(
        .DEPTH (IFQ_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (q_flush),
        .push_valid (q_push),
        .push_data  (q_push_data),
        .pop        (q_pop),
        .head_valid (out_valid),
        .head_data  (q_head),
        .occupancy  (q_occ)
    );

    assign out_inst = q_head.inst;
    assign out_pc   = q_head.pc;

endmodule
